// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative RV64M multiply/divide unit.
//   mdufunc_t   : 4-bit operation select carried on the op port
//   mdu_state_t : sequencer state
//   sext32      : sign-extend a 32-bit value to 64 bits
//   neg_if      : conditional two's-complement negation
package mdu_iter_pkg;

    typedef enum logic [3:0] {
        MDU_MUL   = 4'd0,
        MDU_MULW  = 4'd1,
        MDU_DIV   = 4'd2,
        MDU_DIVU  = 4'd3,
        MDU_REM   = 4'd4,
        MDU_REMU  = 4'd5,
        MDU_DIVW  = 4'd6,
        MDU_DIVUW = 4'd7,
        MDU_REMW  = 4'd8,
        MDU_REMUW = 4'd9
    } mdufunc_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

    function automatic logic [63:0] sext32(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    function automatic logic [63:0] neg_if(input logic [63:0] x, input logic n);
        return n ? (~x + 64'd1) : x;
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-divide iteration over the {remainder, quotient} pair.
// The dividend is shifted out of the top of the quotient register into the
// remainder while quotient bits are shifted in at the bottom.
//   i_rem / i_quo : current partial remainder / dividend-quotient register
//   i_div         : divisor magnitude
//   o_rem / o_quo : values after this iteration
module mdu_div_step
    import mdu_iter_pkg::*;
(
    input  logic [63:0] i_rem,
    input  logic [63:0] i_quo,
    input  logic [63:0] i_div,
    output logic [63:0] o_rem,
    output logic [63:0] o_quo
);

    // 65 bits because the shifted remainder can reach 2*divisor-1
    logic [64:0] w_shift;
    logic [64:0] w_diff;

    // Trial subtraction; keep the difference only when it does not borrow
    always_comb begin
        w_shift = {i_rem, i_quo[63]};
        w_diff  = w_shift - {1'b0, i_div};
        if (w_diff[64] == 1'b0) begin
            o_rem = w_diff[63:0];
            o_quo = {i_quo[62:0], 1'b1};
        end else begin
            o_rem = w_shift[63:0];
            o_quo = {i_quo[62:0], 1'b0};
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide unit (64-iteration shift-add multiply,
// restoring divide on magnitudes). Divide by zero completes immediately.
//   clk, reset (async active-low), flush (synchronous abort)
//   in_valid/in_ready : request handshake with op, a, b
//   out_valid/out_ready : response handshake with registered result c
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int ITER = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  op,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] c
);

    localparam logic [5:0] LAST = 6'(ITER - 1);

    mdu_state_t  r_state;
    logic [5:0]  r_cnt;
    logic [63:0] r_acc;   // product accumulator / partial remainder
    logic [63:0] r_q;     // multiplier (shifts right) / dividend-quotient
    logic [63:0] r_d;     // multiplicand (shifts left) / divisor magnitude
    logic        r_is_mul;
    logic        r_is_w;
    logic        r_is_rem;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [63:0] r_c;

    logic        w_is_mul, w_is_w, w_is_signed, w_is_rem;
    logic [63:0] w_a_prep, w_b_prep, w_a_mag, w_b_mag;
    logic        w_a_neg, w_b_neg, w_div_zero;
    logic [63:0] w_fast_res;
    logic [63:0] w_div_rem, w_div_quo;
    logic [63:0] w_acc_n, w_q_n, w_d_n;
    logic [63:0] w_res_raw, w_final;

    // Operation decode; unknown encodings behave as MUL
    always_comb begin
        w_is_mul    = 1'b0;
        w_is_w      = 1'b0;
        w_is_signed = 1'b0;
        w_is_rem    = 1'b0;
        case (op)
            MDU_MUL:   w_is_mul = 1'b1;
            MDU_MULW:  begin w_is_mul = 1'b1; w_is_w = 1'b1; end
            MDU_DIV:   w_is_signed = 1'b1;
            MDU_DIVU:  w_is_signed = 1'b0;
            MDU_REM:   begin w_is_signed = 1'b1; w_is_rem = 1'b1; end
            MDU_REMU:  w_is_rem = 1'b1;
            MDU_DIVW:  begin w_is_w = 1'b1; w_is_signed = 1'b1; end
            MDU_DIVUW: w_is_w = 1'b1;
            MDU_REMW:  begin w_is_w = 1'b1; w_is_signed = 1'b1; w_is_rem = 1'b1; end
            MDU_REMUW: begin w_is_w = 1'b1; w_is_rem = 1'b1; end
            default:   w_is_mul = 1'b1;
        endcase
    end

    // Operand preparation: W narrowing, magnitudes, divide-by-zero result
    always_comb begin
        if (w_is_w) begin
            w_a_prep = w_is_signed ? sext32(a[31:0]) : {32'd0, a[31:0]};
            w_b_prep = w_is_signed ? sext32(b[31:0]) : {32'd0, b[31:0]};
        end else begin
            w_a_prep = a;
            w_b_prep = b;
        end
        w_a_neg    = w_is_signed & w_a_prep[63];
        w_b_neg    = w_is_signed & w_b_prep[63];
        w_a_mag    = neg_if(w_a_prep, w_a_neg);
        w_b_mag    = neg_if(w_b_prep, w_b_neg);
        w_div_zero = !w_is_mul && (w_b_prep == 64'd0);
        if (w_is_rem) begin
            w_fast_res = w_is_w ? sext32(a[31:0]) : w_a_prep;
        end else begin
            w_fast_res = 64'hFFFF_FFFF_FFFF_FFFF;
        end
    end

    mdu_div_step u_div_step (
        .i_rem (r_acc),
        .i_quo (r_q),
        .i_div (r_d),
        .o_rem (w_div_rem),
        .o_quo (w_div_quo)
    );

    // Next datapath values for one iteration plus the result if it is the last
    always_comb begin
        if (r_is_mul) begin
            w_acc_n   = r_q[0] ? (r_acc + r_d) : r_acc;
            w_q_n     = {1'b0, r_q[63:1]};
            w_d_n     = {r_d[62:0], 1'b0};
            w_res_raw = w_acc_n;
        end else begin
            w_acc_n   = w_div_rem;
            w_q_n     = w_div_quo;
            w_d_n     = r_d;
            w_res_raw = r_is_rem ? neg_if(w_div_rem, r_neg_r)
                                 : neg_if(w_div_quo, r_neg_q);
        end
        w_final = r_is_w ? sext32(w_res_raw[31:0]) : w_res_raw;
    end

    // Sequencer and datapath registers; flush dominates every other input
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= 6'd0;
            r_acc    <= 64'd0;
            r_q      <= 64'd0;
            r_d      <= 64'd0;
            r_is_mul <= 1'b0;
            r_is_w   <= 1'b0;
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_c      <= 64'd0;
        end else if (flush) begin
            r_state <= IDLE;
            r_cnt   <= 6'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_cnt    <= 6'd0;
                        r_acc    <= 64'd0;
                        r_is_mul <= w_is_mul;
                        r_is_w   <= w_is_w;
                        r_is_rem <= w_is_rem;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        if (w_is_mul) begin
                            r_q <= w_b_prep;
                            r_d <= w_a_prep;
                        end else begin
                            r_q <= w_a_mag;
                            r_d <= w_b_mag;
                        end
                        if (w_div_zero) begin
                            r_state <= DONE;
                            r_c     <= w_fast_res;
                        end else begin
                            r_state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    r_acc <= w_acc_n;
                    r_q   <= w_q_n;
                    r_d   <= w_d_n;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == LAST) begin
                        r_state <= DONE;
                        r_c     <= w_final;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign c         = r_c;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: hand-computed results, latency, back-pressure,
// flush and asynchronous reset behaviour.
module tb_mdu_iter;
    import mdu_iter_pkg::*;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] c;

    int n_total;
    int n_pass;

    mdu_iter dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, wait (bounded) for the result, check latency and c, retire it
    task automatic do_op(input string tag, input logic [3:0] f, input logic [63:0] xa,
                         input logic [63:0] xb, input logic [63:0] exp_c, input int exp_lat);
        int lat;
        op       = f;
        a        = xa;
        b        = xb;
        in_valid = 1'b1;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_c"}, c, exp_c);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int seen;
        n_total   = 0;
        n_pass    = 0;
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 4'd0;
        a         = 64'd0;
        b         = 64'd0;
        #3;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_c", c, 64'd0);
        repeat (2) tick();
        reset = 1'b1;
        tick();

        // Signed divide / remainder with mixed signs
        do_op("div_m7_2", MDU_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        do_op("rem_m7_2", MDU_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        // Divide by zero fast path
        do_op("divu_5_0", MDU_DIVU, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        do_op("remu_5_0", MDU_REMU, 64'd5, 64'd0, 64'd5, 1);
        do_op("remuw_by0", MDU_REMUW, 64'h0000_0001_8000_0000, 64'h0000_0002_0000_0000,
              64'hFFFF_FFFF_8000_0000, 1);
        // Signed overflow
        do_op("div_ovf", MDU_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h8000_0000_0000_0000, 65);
        do_op("rem_ovf", MDU_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65);
        do_op("divw_ovf", MDU_DIVW, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
              64'hFFFF_FFFF_8000_0000, 65);
        do_op("divuw", MDU_DIVUW, 64'h1234_5678_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 65);
        do_op("remw_m7_2", MDU_REMW, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        // Multiply
        do_op("mulw", MDU_MULW, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        do_op("mul_m1_3", MDU_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        do_op("unknown_op", 4'd12, 64'd6, 64'd7, 64'd42, 65);

        // Back-pressure: result held while out_ready is low, no new accept
        op = MDU_MUL; a = 64'd6; b = 64'd7; in_valid = 1'b1;
        tick();
        seen = 1;
        while (!out_valid && seen < 200) begin
            tick();
            seen++;
        end
        check("bp_latency", 64'(seen), 64'd65);
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_c", c, 64'd42);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        check("bp_release_out_valid", 64'(out_valid), 64'd0);

        // Flush at counter 20 together with a new request
        op = MDU_DIVU; a = 64'd1000; b = 64'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        flush    = 1'b1;
        in_valid = 1'b1;
        op       = MDU_MUL;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            if (out_valid) seen++;
            tick();
        end
        check("flush_no_result", 64'(seen), 64'd0);
        do_op("after_flush", MDU_REMU, 64'd100, 64'd7, 64'd2, 65);

        // Flush discards an untaken DONE result
        op = MDU_DIVU; a = 64'd9; b = 64'd0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("done_before_flush", 64'(out_valid), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("done_flushed", 64'(out_valid), 64'd0);

        // Asynchronous reset mid-BUSY
        op = MDU_DIV; a = 64'd77; b = 64'd5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        reset = 1'b0;
        #1;
        check("rst_busy_in_ready", 64'(in_ready), 64'd1);
        check("rst_busy_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy_c", c, 64'd0);
        tick();
        reset = 1'b1;
        tick();
        do_op("after_reset", MDU_DIV, 64'd77, 64'd5, 64'd15, 65);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
